chip8_core: RTL and testbench
=============================

# chip8_core

Parametrised CHIP-8 execution core: fetches big-endian 16-bit opcodes from an external byte memory over a req/ack handshake and executes an extended instruction set. The extended set covers ALU ops, the I register, bulk register load/store, and optionally random numbers. It keeps an internal return stack and reports halt/error status. It is the next-generation CPU for the FPGA CHIP-8 design, with the memory array moved out of the core so it can be shared with the display and loader logic.

## Interface
- `ADDR_W`, 12: memory address width; PC, I and all address arithmetic wrap mod 2^ADDR_W.
- `START_PC`, 'h200: PC value after reset.
- `STACK_DEPTH`, 16: return-stack entries, ≥1.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: transfer request, held until acked.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`.
- `mem_addr` out ADDR_W: byte address.
- `mem_wdata` out 8: write byte.
- `mem_ack` in 1: transfer completes in any cycle with `mem_req && mem_ack`.
- `mem_rdata` in 8: read byte, valid in the ack cycle only.
- `halted` out 1: core stopped (EXIT or error).
- `error` out 1: stack overflow/underflow occurred.
- `debug_pc` out ADDR_W: current PC.

## Operation
- States: START → FETCH_HI → FETCH_LO → DECODE → (FETCH_HI | XFER | HALT). XFER loops for Fx55/Fx65.
- START lasts exactly one cycle after reset release and issues no request.
- FETCH_HI reads [PC]; FETCH_LO reads [PC+1]; each waits on ack.
- DECODE executes in one cycle. Default next PC = PC+2.
- Opcodes:
  - 00EE RET: if sp==0 → error. Otherwise sp−1, PC=stack[sp−1]+2.
  - 00FD EXIT → HALT.
  - 1nnn JP: PC=nnn.
  - 2nnn CALL: if sp==STACK_DEPTH → error. Otherwise stack[sp]=PC, sp+1, PC=nnn.
  - 3xkk, 4xkk, 5xy0, 9xy0: skip (PC+4) on Vx==kk, Vx!=kk, Vx==Vy, Vx!=Vy respectively.
  - 6xkk: Vx=kk. 7xkk: Vx=Vx+kk mod 256, VF unchanged.
  - 8xy0/1/2/3: MOV/OR/AND/XOR, VF unchanged.
  - 8xy4: Vx=Vx+Vy, VF=carry.
  - 8xy5: Vx=Vx−Vy, VF=(Vx≥Vy).
  - 8xy7: Vx=Vy−Vx, VF=(Vy≥Vx).
  - 8xy6: VF=Vx[0], Vx>>=1. 8xyE: VF=Vx[7], Vx<<=1. Both use Vx, not Vy.
  - Annn: I=nnn. Bnnn: PC=nnn+V0 mod 2^ADDR_W. Fx1E: I=I+Vx mod 2^ADDR_W.
  - Fx55: write V0..Vx to [I..I+x]. Fx65: read [I..I+x] into V0..Vx. I is unchanged afterwards.
  - Cxkk: see Configuration.
  - All other opcodes are NOPs.
- Flag-writing ops with x==F: the flag result wins over the arithmetic result.
- Error: set `error`=1 and `halted`=1, go to HALT, leave PC unchanged.
- HALT is absorbing until reset; no requests are issued in HALT.
- Comparisons and ALU operands use register values as they were at the start of DECODE.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `halted`=0, `error`=0, `debug_pc`=START_PC. Internally V0..VF=0, I=0, sp=0.
- `mem_req` is registered: first asserted the second clk edge after `rst_n` rises.
- Request outputs stay stable from assertion until the ack cycle.
- A new request (new address) may be presented the cycle after an ack. Back-to-back transfers need no idle cycle.
- With a zero-wait memory (ack in the first req cycle): ordinary instruction = 3 cycles (FETCH_HI, FETCH_LO, DECODE); Fx55/Fx65 add x+1 cycles.
- Reset assertion mid-transfer aborts immediately. `mem_req` drops asynchronously and all state returns to reset values.
- `mem_ack` while `mem_req`=0 is ignored.

## Configuration
- `CHIP8_CORE_RAND_EN` defined: Cxkk sets Vx = lfsr[7:0] & kk.
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 'hACE1 at reset.
  - Steps every cycle, including during waits.
- Undefined: Cxkk is a NOP (PC+2, Vx unchanged) and no LFSR is instantiated.

## Test plan
- Zero-wait memory, program at 'h200 = 60 05 70 FF 00 FD → V0='h04, VF=0, `halted` after 9 cycles, `debug_pc`='h204.
- 60 F0 61 20 80 14 → V0='h10, VF=1. Then 80 15 with V1='h20 → V0='hF0, VF=0.
- Memory acking with 3 wait cycles: `mem_addr` and `mem_req` stay stable until ack, and the instruction completes with correct results.
- 17 nested CALLs with STACK_DEPTH=16 → `error`=1, `halted`=1 on the 17th, no further `mem_req`. Separately, RET at sp=0 → `error`=1.
- A3 00, 62 07, 63 09, F3 55, then clear V0..V3, then F3 65 → bytes at 'h300..'h303 = 07?/09 pattern written, V0..V3 restored, I='h300.
- Assert `rst_n` low during FETCH_LO with `mem_req`=1 → `mem_req`=0 immediately. After release, the first fetch is from START_PC.

Source files
------------

// File: rtl/chip8_core.sv
// chip8_core: CHIP-8 execution core fetching big-endian opcodes from an external
// byte memory over a req/ack handshake, with internal return stack and V0..VF/I.
// Optional feature macro: CHIP8_CORE_RAND_EN enables Cxkk (LFSR-based random byte).
module chip8_core #(
    parameter int ADDR_W      = 12,
    parameter int START_PC    = 'h200,
    parameter int STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] debug_pc
);
    localparam int                SP_W     = $clog2(STACK_DEPTH + 1);
    localparam int                IDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(START_PC);

    typedef enum logic [2:0] {START, FETCH_HI, FETCH_LO, DECODE, XFER, HALT} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0] pc, pc_next, i_reg, i_next, addr_next;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp, sp_next, sp_dec;
    logic [7:0]        v [16];
    logic [7:0]        op_hi, op_hi_next, op_lo, op_lo_next, wdata_next;
    logic [3:0]        cnt, cnt_next, cnt_inc;
    logic              req_next, we_next, halted_next, error_next;
    logic              push, v_we, vf_we, vf_data;
    logic [3:0]        v_idx;
    logic [7:0]        v_data;

    logic [15:0]       opcode;
    logic [3:0]        x, y;
    logic [7:0]        kk, vx, vy;
    logic [8:0]        sum;
    logic [ADDR_W-1:0] nnn, pc_plus2;

    assign opcode   = {op_hi, op_lo};
    assign x        = opcode[11:8];
    assign y        = opcode[7:4];
    assign kk       = opcode[7:0];
    assign nnn      = ADDR_W'(opcode[11:0]);
    assign vx       = v[x];
    assign vy       = v[y];
    assign sum      = {1'b0, vx} + {1'b0, vy};
    assign pc_plus2 = pc + ADDR_W'(2);
    assign sp_dec   = sp - SP_W'(1);
    assign cnt_inc  = cnt + 4'd1;
    assign debug_pc = pc;

`ifdef CHIP8_CORE_RAND_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11), advancing every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= START;
        else        state <= state_next;
    end

    // Next-state, execute and memory-request logic for every state
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        i_next      = i_reg;
        sp_next     = sp;
        op_hi_next  = op_hi;
        op_lo_next  = op_lo;
        cnt_next    = cnt;
        req_next    = mem_req;
        we_next     = mem_we;
        addr_next   = mem_addr;
        wdata_next  = mem_wdata;
        halted_next = halted;
        error_next  = error;
        push        = 1'b0;
        v_we        = 1'b0;
        v_idx       = x;
        v_data      = 8'h00;
        vf_we       = 1'b0;
        vf_data     = 1'b0;
        case (state)
            START: state_next = FETCH_HI;
            FETCH_HI: begin
                if (!mem_req) begin
                    req_next  = 1'b1;
                    we_next   = 1'b0;
                    addr_next = pc;
                end else if (mem_ack) begin
                    op_hi_next = mem_rdata;
                    addr_next  = pc + ADDR_W'(1);
                    state_next = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (mem_ack) begin
                    op_lo_next = mem_rdata;
                    req_next   = 1'b0;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                pc_next    = pc_plus2;
                state_next = FETCH_HI;
                case (opcode[15:12])
                    4'h0: begin
                        if (opcode == 16'h00EE) begin
                            if (sp == '0) begin
                                error_next = 1'b1;
                                state_next = HALT;
                            end else begin
                                sp_next = sp_dec;
                                pc_next = stack[sp_dec[IDX_W-1:0]] + ADDR_W'(2);
                            end
                        end else if (opcode == 16'h00FD) begin
                            state_next = HALT;
                        end
                    end
                    4'h1: pc_next = nnn;
                    4'h2: begin
                        if (sp == SP_FULL) begin
                            error_next = 1'b1;
                            state_next = HALT;
                        end else begin
                            push    = 1'b1;
                            sp_next = sp + SP_W'(1);
                            pc_next = nnn;
                        end
                    end
                    4'h3: if (vx == kk) pc_next = pc + ADDR_W'(4);
                    4'h4: if (vx != kk) pc_next = pc + ADDR_W'(4);
                    4'h5: if (opcode[3:0] == 4'h0 && vx == vy) pc_next = pc + ADDR_W'(4);
                    4'h9: if (opcode[3:0] == 4'h0 && vx != vy) pc_next = pc + ADDR_W'(4);
                    4'h6: begin v_we = 1'b1; v_data = kk; end
                    4'h7: begin v_we = 1'b1; v_data = vx + kk; end
                    4'h8: begin
                        case (opcode[3:0])
                            4'h0: begin v_we = 1'b1; v_data = vy; end
                            4'h1: begin v_we = 1'b1; v_data = vx | vy; end
                            4'h2: begin v_we = 1'b1; v_data = vx & vy; end
                            4'h3: begin v_we = 1'b1; v_data = vx ^ vy; end
                            4'h4: begin v_we = 1'b1; v_data = sum[7:0]; vf_we = 1'b1; vf_data = sum[8]; end
                            4'h5: begin v_we = 1'b1; v_data = vx - vy; vf_we = 1'b1; vf_data = (vx >= vy); end
                            4'h7: begin v_we = 1'b1; v_data = vy - vx; vf_we = 1'b1; vf_data = (vy >= vx); end
                            4'h6: begin v_we = 1'b1; v_data = {1'b0, vx[7:1]}; vf_we = 1'b1; vf_data = vx[0]; end
                            4'hE: begin v_we = 1'b1; v_data = {vx[6:0], 1'b0}; vf_we = 1'b1; vf_data = vx[7]; end
                            default: ;
                        endcase
                    end
                    4'hA: i_next = nnn;
                    4'hB: pc_next = nnn + ADDR_W'(v[0]);
                    4'hC: begin
`ifdef CHIP8_CORE_RAND_EN
                        v_we   = 1'b1;
                        v_data = lfsr[7:0] & kk;
`endif
                    end
                    4'hF: begin
                        case (kk)
                            8'h1E: i_next = i_reg + ADDR_W'(vx);
                            8'h55, 8'h65: begin
                                state_next = XFER;
                                req_next   = 1'b1;
                                we_next    = (kk == 8'h55);
                                addr_next  = i_reg;
                                wdata_next = v[0];
                                cnt_next   = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
                if (state_next == HALT) begin
                    pc_next     = pc;
                    req_next    = 1'b0;
                    halted_next = 1'b1;
                end else if (state_next == FETCH_HI) begin
                    req_next  = 1'b1;
                    we_next   = 1'b0;
                    addr_next = pc_next;
                end
            end
            XFER: begin
                if (mem_ack) begin
                    if (!mem_we) begin
                        v_we   = 1'b1;
                        v_idx  = cnt;
                        v_data = mem_rdata;
                    end
                    if (cnt == x) begin
                        state_next = FETCH_HI;
                        we_next    = 1'b0;
                        addr_next  = pc;
                    end else begin
                        cnt_next   = cnt_inc;
                        addr_next  = i_reg + ADDR_W'(cnt_inc);
                        wdata_next = v[cnt_inc];
                    end
                end
            end
            HALT: ;
            default: state_next = HALT;
        endcase
    end

    // Architectural registers, return stack and registered memory-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= PC_RESET;
            i_reg     <= '0;
            sp        <= '0;
            op_hi     <= 8'h00;
            op_lo     <= 8'h00;
            cnt       <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            halted    <= 1'b0;
            error     <= 1'b0;
            for (int k = 0; k < 16; k++) v[k] <= 8'h00;
            for (int k = 0; k < STACK_DEPTH; k++) stack[k] <= '0;
        end else begin
            pc        <= pc_next;
            i_reg     <= i_next;
            sp        <= sp_next;
            op_hi     <= op_hi_next;
            op_lo     <= op_lo_next;
            cnt       <= cnt_next;
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            halted    <= halted_next;
            error     <= error_next;
            if (push)  stack[sp[IDX_W-1:0]] <= pc;
            if (v_we)  v[v_idx] <= v_data;
            if (vf_we) v[15] <= {7'd0, vf_data};
        end
    end
endmodule

// File: tb/tb_chip8_core.sv
// tb_chip8_core: self-checking bench for chip8_core with a byte-memory model,
// configurable ack latency and a scoreboard of expected memory writes.
module tb_chip8_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ack, halted, error;
    logic [11:0] mem_addr, debug_pc;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem [0:4095];
    logic [7:0]  prog [$];
    logic [19:0] exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    bit          stray_ack = 1'b0;
    bit          hold_pending = 1'b0;
    logic [21:0] held;

    // Free-running clock
    always #5 clk = ~clk;

    chip8_core #(.ADDR_W(12), .START_PC('h200), .STACK_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .halted(halted), .error(error), .debug_pc(debug_pc)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expectWrite(input logic [11:0] addr, input logic [7:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Hold the core in reset, clear memory and place the program at 'h200
    task automatic loadProgram();
        rst_n = 1'b0;
        hold_pending = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        for (int k = 0; k < prog.size(); k++) mem[12'(32'h200 + k)] = prog[k];
    endtask

    // Release reset on a falling edge with the chosen ack latency
    task automatic applyStimulus(input int waits);
        wait_cycles = waits;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runToHalt(output int n);
        n = 0;
        while (halted !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halted", 32'(halted), 32'd1);
    endtask

    task automatic finishTest(input string tag);
        checkOutput({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Memory model: decides ack on the falling edge, checks request stability and scoreboards writes
    initial begin
        logic [20:0] got21, exp21;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (hold_pending)
                checkOutput("req_hold", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'(held));
            hold_pending = 1'b0;
            mem_ack = 1'b0;
            if (rst_n && mem_req) begin
                if (wait_cnt >= wait_cycles) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        got21 = {1'b1, mem_addr, mem_wdata};
                        exp21 = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 21'h0;
                        checkOutput("mem_write", 32'(got21), 32'(exp21));
                    end else begin
                        mem_rdata = mem[mem_addr];
                    end
                end else begin
                    wait_cnt++;
                    hold_pending = 1'b1;
                    held = {1'b1, mem_we, mem_addr, mem_wdata};
                end
            end else begin
                wait_cnt = 0;
                mem_ack  = rst_n & stray_ack;
            end
        end
    end

    // Test sequence
    initial begin
        int n;
        logic [11:0] a;
        bit seen;

        // Reset values, then EXIT timing
        prog = {8'h60, 8'h05, 8'h70, 8'hFF, 8'h00, 8'hFD};
        loadProgram();
        @(negedge clk);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_pc", 32'(debug_pc), 32'h200);
        applyStimulus(0);
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checkOutput("first_req_edge", 32'(n), 32'd2);
        checkOutput("first_addr", 32'(mem_addr), 32'h200);
        runToHalt(n);
        checkOutput("exit_cycles", 32'(n), 32'd9);
        checkOutput("exit_pc", 32'(debug_pc), 32'h204);
        checkOutput("exit_err", 32'(error), 32'd0);

        // 7xkk wraps without touching VF, observed through FF55, zero-wait then 3 waits
        for (int w = 0; w < 4; w += 3) begin
            prog = {8'h60, 8'h05, 8'h70, 8'hFF, 8'hA3, 8'h00, 8'hFF, 8'h55, 8'h00, 8'hFD};
            loadProgram();
            expectWrite(12'h300, 8'h04);
            for (int k = 1; k < 16; k++) expectWrite(12'(32'h300 + k), 8'h00);
            applyStimulus(w);
            runToHalt(n);
            checkOutput("add_pc", 32'(debug_pc), 32'h208);
            finishTest("add");
        end

        // 8xy4 carry then 8xy5 borrow, with stray acks while idle
        prog = {8'h60, 8'hF0, 8'h61, 8'h20, 8'h80, 8'h14, 8'hA3, 8'h00, 8'hFF, 8'h55,
                8'h80, 8'h15, 8'hA3, 8'h10, 8'hFF, 8'h55, 8'h00, 8'hFD};
        loadProgram();
        stray_ack = 1'b1;
        expectWrite(12'h300, 8'h10);
        expectWrite(12'h301, 8'h20);
        for (int k = 2; k < 15; k++) expectWrite(12'(32'h300 + k), 8'h00);
        expectWrite(12'h30F, 8'h01);
        expectWrite(12'h310, 8'hF0);
        expectWrite(12'h311, 8'h20);
        for (int k = 2; k < 16; k++) expectWrite(12'(32'h310 + k), 8'h00);
        applyStimulus(1);
        runToHalt(n);
        stray_ack = 1'b0;
        finishTest("carry");

        // ALU mix, skips and flag-over-result on VF
        prog = {8'h60, 8'h81, 8'h80, 8'h06, 8'h61, 8'hC3, 8'h81, 8'h0E, 8'h62, 8'h33,
                8'h63, 8'h33, 8'h52, 8'h30, 8'h64, 8'hEE, 8'h93, 8'h20, 8'h65, 8'h5A,
                8'h35, 8'h5A, 8'h66, 8'h11, 8'h47, 8'h01, 8'h67, 8'h22, 8'h68, 8'h0F,
                8'h88, 8'h32, 8'h69, 8'hF0, 8'h89, 8'h31, 8'h6A, 8'h55, 8'h8A, 8'h23,
                8'h6B, 8'h05, 8'h8B, 8'h07, 8'h6C, 8'h10, 8'h8C, 8'h35, 8'h6D, 8'h0B,
                8'h8D, 8'h30, 8'h6F, 8'hFF, 8'h6E, 8'h01, 8'h8F, 8'hE4, 8'hA3, 8'h00,
                8'hFF, 8'h55, 8'h00, 8'hFD};
        loadProgram();
        expectWrite(12'h300, 8'h40); expectWrite(12'h301, 8'h86);
        expectWrite(12'h302, 8'h33); expectWrite(12'h303, 8'h33);
        expectWrite(12'h304, 8'h00); expectWrite(12'h305, 8'h5A);
        expectWrite(12'h306, 8'h00); expectWrite(12'h307, 8'h00);
        expectWrite(12'h308, 8'h03); expectWrite(12'h309, 8'hF3);
        expectWrite(12'h30A, 8'h66); expectWrite(12'h30B, 8'h3B);
        expectWrite(12'h30C, 8'hDD); expectWrite(12'h30D, 8'h33);
        expectWrite(12'h30E, 8'h01); expectWrite(12'h30F, 8'h01);
        applyStimulus(0);
        runToHalt(n);
        checkOutput("alu_pc", 32'(debug_pc), 32'h23E);
        finishTest("alu");

        // Bulk store, clear, bulk load, store again: I must be unchanged
        prog = {8'hA3, 8'h00, 8'h60, 8'h0A, 8'h61, 8'h0B, 8'h62, 8'h07, 8'h63, 8'h09,
                8'hF3, 8'h55, 8'h60, 8'h00, 8'h61, 8'h00, 8'h62, 8'h00, 8'h63, 8'h00,
                8'hF3, 8'h65, 8'hF3, 8'h55, 8'h00, 8'hFD};
        loadProgram();
        for (int r = 0; r < 2; r++) begin
            expectWrite(12'h300, 8'h0A); expectWrite(12'h301, 8'h0B);
            expectWrite(12'h302, 8'h07); expectWrite(12'h303, 8'h09);
        end
        applyStimulus(2);
        runToHalt(n);
        checkOutput("xfer_mem302", 32'(mem[12'h302]), 32'h07);
        finishTest("xfer");

        // CALL / RET / JP / Bnnn
        prog = {8'h22, 8'h06, 8'h12, 8'h0A, 8'h00, 8'hFD, 8'h60, 8'h42, 8'h00, 8'hEE,
                8'hA3, 8'h00, 8'hF0, 8'h55, 8'hB2, 8'h10, 8'h00, 8'hEE};
        loadProgram();
        mem[12'h252] = 8'h00;
        mem[12'h253] = 8'hFD;
        expectWrite(12'h300, 8'h42);
        applyStimulus(0);
        runToHalt(n);
        checkOutput("flow_pc", 32'(debug_pc), 32'h252);
        checkOutput("flow_err", 32'(error), 32'd0);
        finishTest("flow");

        // 17 nested calls overflow a 16-entry stack
        prog.delete();
        for (int k = 0; k < 17; k++) begin
            a = 12'(32'h202 + 2 * k);
            prog.push_back({4'h2, a[11:8]});
            prog.push_back(a[7:0]);
        end
        loadProgram();
        applyStimulus(1);
        runToHalt(n);
        checkOutput("ovf_err", 32'(error), 32'd1);
        checkOutput("ovf_pc", 32'(debug_pc), 32'h220);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (mem_req !== 1'b0) seen = 1'b1; end
        checkOutput("ovf_no_req", 32'(seen), 32'd0);
        finishTest("ovf");

        // RET with empty stack
        prog = {8'h00, 8'hEE};
        loadProgram();
        applyStimulus(0);
        runToHalt(n);
        checkOutput("udf_err", 32'(error), 32'd1);
        checkOutput("udf_pc", 32'(debug_pc), 32'h200);
        finishTest("udf");

        // Reset during FETCH_LO drops mem_req at once; restart from 'h200
        prog = {8'h60, 8'h05, 8'h70, 8'hFF, 8'hA3, 8'h00, 8'hFF, 8'h55, 8'h00, 8'hFD};
        loadProgram();
        applyStimulus(3);
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr == 12'h201) && n < 50) begin @(negedge clk); n++; end
        checkOutput("fetch_lo_seen", 32'(mem_addr), 32'h201);
        #1;
        hold_pending = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_req", 32'(mem_req), 32'd0);
        checkOutput("abort_pc", 32'(debug_pc), 32'h200);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expectWrite(12'h300, 8'h04);
        for (int k = 1; k < 16; k++) expectWrite(12'(32'h300 + k), 8'h00);
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checkOutput("restart_addr", 32'(mem_addr), 32'h200);
        runToHalt(n);
        finishTest("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
